pll_clken_gen: RTL and testbench

PLL_CLKEN_GEN -- requirements
Module: pll_clken_gen

---
 rtl/pll_clken_pkg.sv | 27 ++
 rtl/pll_clken_div.sv | 66 ++++++
 rtl/pll_clken_gen.sv | 193 +++++++++++++++++++
 tb/tb_pll_clken_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_clken_pkg.sv
// ---------------------------------------------------------------------------
// pll_clken_pkg
// Shared definitions for the PLL clock-enable generator:
//   - pllState_e : lock/run state machine encoding
//   - MAX_CLOCKS : upper bound on the number of clock-enable channels
//   - FILT_W     : width of the lock filter counter
//   - chLsb()    : bit offset of channel idx inside a packed per-channel bus
// ---------------------------------------------------------------------------
package pll_clken_pkg;

   localparam int unsigned MAX_CLOCKS = 18;
   localparam int unsigned FILT_W     = 16;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      RUN       = 2'd2,
      LOST      = 2'd3
   } pllState_e;

   // Per-channel fields are packed with channel 0 in the least significant
   // slot, so channel idx starts at idx*width.
   function automatic int unsigned chLsb(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/pll_clken_div.sv
// ---------------------------------------------------------------------------
// pll_clken_div
// One clock-enable channel: a modulo-div counter that emits a single-cycle
// enable pulse when it reaches div-1. div of 0 or 1 means "every cycle".
//
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset, clears the counter
//   i_div    divide ratio
//   i_phase  starting count loaded by i_load (0 if not below i_div)
//   i_load   load the starting count this cycle (takes priority)
//   i_run    count enable; also gates the pulse output
//   o_clken  one-cycle enable pulse
// ---------------------------------------------------------------------------
module pll_clken_div
   import pll_clken_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [CNT_W-1:0] i_div,
   input  logic [CNT_W-1:0] i_phase,
   input  logic             i_load,
   input  logic             i_run,
   output logic             o_clken
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_last;
   logic [CNT_W-1:0] w_loadVal;
   logic             w_bypass;
   logic             w_atLast;
   logic             w_pastLast;

   // Decode the terminal count. A phase that is not below div would never
   // be hit by the wrap logic, so it collapses to 0. The wrap uses >= so
   // the counter can never run past div-1 even if div shrinks underneath it.
   always_comb begin
      w_bypass   = (i_div <= ONE);
      w_last     = i_div - ONE;
      w_atLast   = (r_cnt == w_last);
      w_pastLast = (r_cnt >= w_last);
      w_loadVal  = (i_phase >= i_div) ? '0 : i_phase;
   end

   // Counter: load has priority, then count/wrap while running, else hold.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= w_loadVal;
      end else if (i_run) begin
         if (w_bypass || w_pastLast) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + ONE;
         end
      end
   end

   assign o_clken = i_run & (w_bypass | w_atLast);

endmodule

// File: rtl/pll_clken_gen.sv
// ---------------------------------------------------------------------------
// pll_clken_gen
// Generates NUM_CLOCKS divided clock-enable pulses once the PLL lock signal
// has been synchronised and seen stable for LOCK_FILTER cycles. Losing lock
// while running silences all outputs immediately and sets a sticky flag.
//
// Ports:
//   refclk     clock (PLL output)
//   rst        asynchronous active-high reset
//   locked     PLL lock indication, asynchronous to refclk
//   div_i      per-channel divide ratios, CNT_W bits per channel
//   phase_i    per-channel starting phase, same packing as div_i
//   cfg_load   strobe capturing div_i/phase_i into shadow registers
//   clr_lost   clears the sticky lock_lost flag
//   clken_o    per-channel one-cycle clock-enable pulses
//   ready      high while running with lock present
//   lock_lost  sticky flag, set when lock drops while running
// ---------------------------------------------------------------------------
module pll_clken_gen
   import pll_clken_pkg::*;
#(
   parameter int unsigned NUM_CLOCKS  = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned LOCK_FILTER = 16
) (
   input  logic                        refclk,
   input  logic                        rst,
   input  logic                        locked,
   input  logic [NUM_CLOCKS*CNT_W-1:0] div_i,
   input  logic [NUM_CLOCKS*CNT_W-1:0] phase_i,
   input  logic                        cfg_load,
   input  logic                        clr_lost,
   output logic [NUM_CLOCKS-1:0]       clken_o,
   output logic                        ready,
   output logic                        lock_lost
);

   localparam logic [FILT_W-1:0]           FILT_LAST = FILT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0]            DIV_ONE   = CNT_W'(1);
   localparam logic [NUM_CLOCKS*CNT_W-1:0] DIV_RESET = {NUM_CLOCKS{DIV_ONE}};

   logic [1:0]                  r_sync;
   logic                        w_lockedS;
   pllState_e                   r_state;
   pllState_e                   w_nextState;
   logic [FILT_W-1:0]           r_filtCnt;
   logic                        w_filtClr;
   logic                        w_filtInc;
   logic                        w_enterRun;
   logic                        w_lossEvent;
   logic                        w_runActive;
   logic                        w_chRun;
   logic                        w_chLoad;
   logic                        r_reloadPending;
   logic                        r_lockLost;
   logic [NUM_CLOCKS*CNT_W-1:0] r_divShadow;
   logic [NUM_CLOCKS*CNT_W-1:0] r_phaseShadow;
   logic [NUM_CLOCKS-1:0]       w_pulse;

   // Two-flop synchroniser for the asynchronous lock input.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], locked};
      end
   end

   assign w_lockedS = r_sync[1];

   // State register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_state <= WAIT_LOCK;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode. The filter counter must see LOCK_FILTER consecutive
   // locked cycles; any dropout sends us back to waiting with a clean count.
   always_comb begin
      w_nextState = r_state;
      w_filtClr   = 1'b0;
      w_filtInc   = 1'b0;
      w_enterRun  = 1'b0;
      w_lossEvent = 1'b0;
      case (r_state)
         WAIT_LOCK: begin
            if (w_lockedS) begin
               w_nextState = FILTER;
               w_filtClr   = 1'b1;
            end
         end
         FILTER: begin
            if (!w_lockedS) begin
               w_nextState = WAIT_LOCK;
               w_filtClr   = 1'b1;
            end else if (r_filtCnt == FILT_LAST) begin
               w_nextState = RUN;
               w_enterRun  = 1'b1;
            end else begin
               w_filtInc   = 1'b1;
            end
         end
         RUN: begin
            if (!w_lockedS) begin
               w_nextState = LOST;
               w_lossEvent = 1'b1;
            end
         end
         LOST: begin
            w_nextState = WAIT_LOCK;
         end
         default: begin
            w_nextState = WAIT_LOCK;
         end
      endcase
   end

   // Lock filter counter.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_filtCnt <= '0;
      end else if (w_filtClr) begin
         r_filtCnt <= '0;
      end else if (w_filtInc) begin
         r_filtCnt <= r_filtCnt + 1'b1;
      end
   end

   // Shadow configuration, captured in any state. Reset defaults to
   // divide-by-1 so an unconfigured block enables every cycle once running.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_divShadow   <= DIV_RESET;
         r_phaseShadow <= '0;
      end else if (cfg_load) begin
         r_divShadow   <= div_i;
         r_phaseShadow <= phase_i;
      end
   end

   // Running is qualified by the live synchronised lock so that a loss
   // silences ready and clken_o in the very cycle it is detected.
   assign w_runActive = (r_state == RUN) && w_lockedS;

   // A config load while running (or on the RUN entry edge, when the
   // counters would otherwise capture stale shadow values) inserts one quiet
   // cycle in which every channel reloads from the new shadow together.
   // A loss in the same cycle wins: no reload is scheduled.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_reloadPending <= 1'b0;
      end else begin
         r_reloadPending <= cfg_load && (w_runActive || w_enterRun);
      end
   end

   assign w_chRun  = w_runActive && !r_reloadPending;
   assign w_chLoad = w_enterRun || (r_reloadPending && w_runActive);

   // Sticky loss flag; a coincident loss overrides a clear.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         r_lockLost <= 1'b0;
      end else if (w_lossEvent) begin
         r_lockLost <= 1'b1;
      end else if (clr_lost) begin
         r_lockLost <= 1'b0;
      end
   end

   // Channel counters.
   for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : gCh
      pll_clken_div #(
         .CNT_W (CNT_W)
      ) uDiv (
         .i_clk   (refclk),
         .i_rst   (rst),
         .i_div   (r_divShadow[chLsb(gi, CNT_W) +: CNT_W]),
         .i_phase (r_phaseShadow[chLsb(gi, CNT_W) +: CNT_W]),
         .i_load  (w_chLoad),
         .i_run   (w_chRun),
         .o_clken (w_pulse[gi])
      );
   end

   assign clken_o   = w_pulse;
   assign ready     = w_runActive;
   assign lock_lost = r_lockLost | w_lossEvent;

endmodule

// File: tb/tb_pll_clken_gen.sv
// ---------------------------------------------------------------------------
// tb_pll_clken_gen
// Self-checking bench for pll_clken_gen (4 channels, 16-bit fields, lock
// filter of 16). Each scenario pushes per-cycle stimulus together with the
// expected outputs onto a scoreboard queue, then pops one entry per refclk
// cycle, drives it, and compares the outputs on the falling edge.
// Expected channel pulses come from a closed-form model: a channel with
// divide d and start s pulses in run cycle n when (s + n) mod d == d-1.
// ---------------------------------------------------------------------------
module tb_pll_clken_gen;

   logic        refclk;
   logic        rst;
   logic        locked;
   logic [63:0] div_i;
   logic [63:0] phase_i;
   logic        cfg_load;
   logic        clr_lost;
   logic [3:0]  clken_o;
   logic        ready;
   logic        lock_lost;

   int vectors;
   int miscompares;

   typedef struct {
      logic        lk;
      logic        clr;
      logic        cfg;
      logic [63:0] dv;
      logic [63:0] ph;
      logic [3:0]  eClk;
      logic        eRdy;
      logic        eLost;
   } vecT;

   vecT sb[$];

   pll_clken_gen #(
      .NUM_CLOCKS  (4),
      .CNT_W       (16),
      .LOCK_FILTER (16)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .locked    (locked),
      .div_i     (div_i),
      .phase_i   (phase_i),
      .cfg_load  (cfg_load),
      .clr_lost  (clr_lost),
      .clken_o   (clken_o),
      .ready     (ready),
      .lock_lost (lock_lost)
   );

   // Free-running reference clock.
   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] e);
      return {e, c, b, a};
   endfunction

   // Reference pulse pattern for run cycle n.
   function automatic logic [3:0] expClken(input logic [63:0] d, input logic [63:0] p, input int n);
      logic [3:0] r;
      int dv, ph, st;
      r = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         dv = {16'd0, d[c*16 +: 16]};
         ph = {16'd0, p[c*16 +: 16]};
         st = (ph >= dv) ? 0 : ph;
         if (dv <= 1) r[c] = 1'b1;
         else         r[c] = (((st + n) % dv) == (dv - 1));
      end
      return r;
   endfunction

   task automatic pushVec(input logic lk, input logic clr, input logic cfg,
                          input logic [63:0] dv, input logic [63:0] ph,
                          input logic [3:0] eClk, input logic eRdy, input logic eLost);
      vecT v;
      v.lk = lk; v.clr = clr; v.cfg = cfg; v.dv = dv; v.ph = ph;
      v.eClk = eClk; v.eRdy = eRdy; v.eLost = eLost;
      sb.push_back(v);
   endtask

   // Configure in WAIT_LOCK, raise lock, expect 18 silent cycles.
   task automatic pushBringUp(input logic [63:0] dv, input logic [63:0] ph);
      pushVec(1'b0, 1'b0, 1'b1, dv, ph, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) pushVec(1'b1, 1'b0, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b0);
   endtask

   task automatic applyStimulusReset();
      rst = 1'b1; locked = 1'b0; clr_lost = 1'b0; cfg_load = 1'b0;
      div_i = '0; phase_i = '0;
      repeat (2) @(negedge refclk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; locked = 1'b1; cfg_load = 1'b1; clr_lost = 1'b1;
      div_i = pack4(16'd7, 16'd7, 16'd7, 16'd7); phase_i = '0;
      @(negedge refclk);
      for (int i = 0; i < 3; i++) begin
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL reset cyc %0d: got clken=%b ready=%b lost=%b, want all 0", i, clken_o, ready, lock_lost);
         end
      end
      applyStimulusReset();
   endtask

   task automatic test_lock_filter();
      vecT v;
      int step = 0;
      applyStimulusReset();
      for (int i = 0; i < 18; i++) pushVec(1'b1, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)  pushVec(1'b1, 1'b0, 1'b0, '0, '0, 4'b1111, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         v = sb.pop_front();
         locked = v.lk; clr_lost = v.clr; cfg_load = v.cfg; div_i = v.dv; phase_i = v.ph;
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== {v.eClk, v.eRdy, v.eLost}) begin
            miscompares++;
            $display("[TB] FAIL lock_filter step %0d: got clken=%b ready=%b lost=%b, want clken=%b ready=%b lost=%b",
                     step, clken_o, ready, lock_lost, v.eClk, v.eRdy, v.eLost);
         end
         step++;
      end
   endtask

   task automatic test_glitch();
      vecT v;
      int step = 0;
      applyStimulusReset();
      for (int i = 0; i < 10; i++) pushVec(1'b1, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)  pushVec(1'b0, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) pushVec(1'b1, 1'b0, 1'b0, '0, '0, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++)  pushVec(1'b1, 1'b0, 1'b0, '0, '0, 4'b1111, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         v = sb.pop_front();
         locked = v.lk; clr_lost = v.clr; cfg_load = v.cfg; div_i = v.dv; phase_i = v.ph;
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== {v.eClk, v.eRdy, v.eLost}) begin
            miscompares++;
            $display("[TB] FAIL glitch step %0d: got clken=%b ready=%b lost=%b, want clken=%b ready=%b lost=%b",
                     step, clken_o, ready, lock_lost, v.eClk, v.eRdy, v.eLost);
         end
         step++;
      end
   endtask

   task automatic test_phase();
      vecT v;
      int step = 0;
      logic [63:0] dv, ph;
      dv = pack4(16'd4, 16'd4, 16'd0, 16'd1);
      ph = pack4(16'd0, 16'd3, 16'd0, 16'd0);
      applyStimulusReset();
      pushBringUp(dv, ph);
      for (int n = 0; n < 12; n++) pushVec(1'b1, 1'b0, 1'b0, dv, ph, expClken(dv, ph, n), 1'b1, 1'b0);
      while (sb.size() > 0) begin
         v = sb.pop_front();
         locked = v.lk; clr_lost = v.clr; cfg_load = v.cfg; div_i = v.dv; phase_i = v.ph;
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== {v.eClk, v.eRdy, v.eLost}) begin
            miscompares++;
            $display("[TB] FAIL phase step %0d: got clken=%b ready=%b lost=%b, want clken=%b ready=%b lost=%b",
                     step, clken_o, ready, lock_lost, v.eClk, v.eRdy, v.eLost);
         end
         step++;
      end
   endtask

   task automatic test_boundary();
      vecT v;
      int step = 0;
      logic [63:0] dv, ph;
      dv = pack4(16'd0, 16'd1, 16'd5, 16'd3);
      ph = pack4(16'd5, 16'd7, 16'd9, 16'd2);
      applyStimulusReset();
      pushBringUp(dv, ph);
      for (int n = 0; n < 10; n++) pushVec(1'b1, 1'b0, 1'b0, dv, ph, expClken(dv, ph, n), 1'b1, 1'b0);
      while (sb.size() > 0) begin
         v = sb.pop_front();
         locked = v.lk; clr_lost = v.clr; cfg_load = v.cfg; div_i = v.dv; phase_i = v.ph;
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== {v.eClk, v.eRdy, v.eLost}) begin
            miscompares++;
            $display("[TB] FAIL boundary step %0d: got clken=%b ready=%b lost=%b, want clken=%b ready=%b lost=%b",
                     step, clken_o, ready, lock_lost, v.eClk, v.eRdy, v.eLost);
         end
         step++;
      end
   endtask

   task automatic test_loss();
      vecT v;
      int step = 0;
      logic [63:0] dv, ph;
      dv = pack4(16'd4, 16'd4, 16'd0, 16'd1);
      ph = pack4(16'd0, 16'd3, 16'd0, 16'd0);
      applyStimulusReset();
      pushBringUp(dv, ph);
      for (int n = 0; n < 5; n++) pushVec(1'b1, 1'b0, 1'b0, dv, ph, expClken(dv, ph, n), 1'b1, 1'b0);
      // Lock drops; the synchroniser keeps RUN alive one more cycle.
      pushVec(1'b0, 1'b1, 1'b0, dv, ph, expClken(dv, ph, 5), 1'b1, 1'b0);
      // Loss cycle: silenced, flag visible.
      pushVec(1'b0, 1'b1, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b1);
      // clr_lost coincides with the loss event: flag must stay set.
      pushVec(1'b0, 1'b1, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b1);
      pushVec(1'b0, 1'b0, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b1);
      pushVec(1'b0, 1'b0, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b1);
      // Later clear takes effect.
      pushVec(1'b0, 1'b1, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b0);
      pushVec(1'b0, 1'b0, 1'b0, dv, ph, 4'b0000, 1'b0, 1'b0);
      while (sb.size() > 0) begin
         v = sb.pop_front();
         locked = v.lk; clr_lost = v.clr; cfg_load = v.cfg; div_i = v.dv; phase_i = v.ph;
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== {v.eClk, v.eRdy, v.eLost}) begin
            miscompares++;
            $display("[TB] FAIL loss step %0d: got clken=%b ready=%b lost=%b, want clken=%b ready=%b lost=%b",
                     step, clken_o, ready, lock_lost, v.eClk, v.eRdy, v.eLost);
         end
         step++;
      end
   endtask

   task automatic test_reload();
      vecT v;
      int step = 0;
      logic [63:0] dvB, phB, dvC, phC;
      dvB = pack4(16'd4, 16'd4, 16'd4, 16'd4);
      phB = pack4(16'd0, 16'd1, 16'd2, 16'd3);
      dvC = pack4(16'd3, 16'd3, 16'd3, 16'd3);
      phC = pack4(16'd0, 16'd1, 16'd2, 16'd0);
      applyStimulusReset();
      pushBringUp(dvB, phB);
      for (int n = 0; n < 6; n++) pushVec(1'b1, 1'b0, 1'b0, dvB, phB, expClken(dvB, phB, n), 1'b1, 1'b0);
      // Mid-run config change: one quiet cycle, then realigned pattern.
      pushVec(1'b1, 1'b0, 1'b1, dvC, phC, 4'b0000, 1'b1, 1'b0);
      for (int n = 0; n < 7; n++) pushVec(1'b1, 1'b0, 1'b0, dvC, phC, expClken(dvC, phC, n), 1'b1, 1'b0);
      while (sb.size() > 0) begin
         v = sb.pop_front();
         locked = v.lk; clr_lost = v.clr; cfg_load = v.cfg; div_i = v.dv; phase_i = v.ph;
         @(posedge refclk); @(negedge refclk);
         vectors++;
         if ({clken_o, ready, lock_lost} !== {v.eClk, v.eRdy, v.eLost}) begin
            miscompares++;
            $display("[TB] FAIL reload step %0d: got clken=%b ready=%b lost=%b, want clken=%b ready=%b lost=%b",
                     step, clken_o, ready, lock_lost, v.eClk, v.eRdy, v.eLost);
         end
         step++;
      end
      // Asynchronous reset while a pulse is being presented.
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({clken_o, ready, lock_lost} !== 6'b000000) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got clken=%b ready=%b lost=%b, want all 0", clken_o, ready, lock_lost);
      end
      @(negedge refclk);
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1; locked = 1'b0; clr_lost = 1'b0; cfg_load = 1'b0;
      div_i = '0; phase_i = '0;
      $display("[TB] starting pll_clken_gen bench");
      test_reset();
      test_lock_filter();
      test_glitch();
      test_phase();
      test_boundary();
      test_loss();
      test_reload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
